// File: rtl/tick_pkg.sv
// Shared definitions for the tick receiver: state encoding, default parameters
// and the saturating increment used by the interval counter.
package tick_pkg;

    localparam int          CNT_W                  = 24;
    localparam logic [23:0] CNT_MAX                = 24'hFFFFFF;
    localparam int          DEF_SYNC_STAGES        = 2;
    localparam logic [23:0] DEF_TIMEOUT_CYCLES     = 24'd3000000;
    localparam int          DEF_LOCK_EDGES         = 4;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } tick_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? CNT_MAX : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flop synchronizer for a single asynchronous level into clk_input.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk_input,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] stage;

    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples the pre-edge value of its neighbour, giving a true shift chain.
    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            stage <= '0;
        end else begin
            stage <= {stage[STAGES-2:0], d};
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/tick_receiver.sv
// Receives an asynchronous toggling tick clock: synchronizes it, strobes its
// edges, measures the half period, detects silence and tracks frequency lock.
module tick_receiver
    import tick_pkg::*;
#(
    parameter int          SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter logic [23:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          LOCK_EDGES     = DEF_LOCK_EDGES
) (
    input  logic             clk_input,
    input  logic             rst_n,
    input  logic             slow_clk_in,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic [CNT_W-1:0] half_period,
    output logic             locked,
    output logic             timeout
);

    localparam logic [3:0] LOCK_CNT = 4'(LOCK_EDGES);

    logic             sync_q;
    logic             hist_q;
    logic             edge_seen;
    logic             timeout_hit;
    logic [CNT_W-1:0] interval_cnt;
    tick_state_t      state, state_next;
    logic [3:0]       edge_cnt, edge_cnt_next;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk_input (clk_input),
        .rst_n     (rst_n),
        .d         (slow_clk_in),
        .q         (sync_q)
    );

    assign edge_seen   = sync_q ^ hist_q;
    // An edge in the same cycle as the silence limit wins; no timeout then.
    assign timeout_hit = !edge_seen && (interval_cnt == TIMEOUT_CYCLES - 24'd1);

    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            hist_q       <= 1'b0;
            tick_rise    <= 1'b0;
            tick_fall    <= 1'b0;
            timeout      <= 1'b0;
            half_period  <= '0;
            interval_cnt <= '0;
        end else begin
            hist_q    <= sync_q;
            tick_rise <= edge_seen &  sync_q;
            tick_fall <= edge_seen & ~sync_q;
            timeout   <= timeout_hit;
            if (edge_seen) begin
                half_period  <= sat_inc(interval_cnt);
                interval_cnt <= '0;
            end else if (timeout_hit) begin
                interval_cnt <= '0;
            end else begin
                interval_cnt <= sat_inc(interval_cnt);
            end
        end
    end

    always_ff @(posedge clk_input or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_UNLOCKED;
            edge_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            state    <= state_next;
            edge_cnt <= edge_cnt_next;
            locked   <= (state == ST_LOCKED);
        end
    end

    // NOTE: both outputs get a default before any branch, so no path leaves
    // them unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        edge_cnt_next = edge_cnt;
        if (timeout_hit) begin
            state_next    = ST_UNLOCKED;
            edge_cnt_next = '0;
        end else if (edge_seen) begin
            unique case (state)
                ST_UNLOCKED: begin
                    edge_cnt_next = 4'd1;
                    state_next    = (LOCK_CNT == 4'd1) ? ST_LOCKED : ST_LOCKING;
                end
                ST_LOCKING: begin
                    edge_cnt_next = edge_cnt + 4'd1;
                    if (edge_cnt_next >= LOCK_CNT) begin
                        state_next = ST_LOCKED;
                    end
                end
                ST_LOCKED: begin
                    edge_cnt_next = LOCK_CNT;
                end
                default: begin
                    state_next    = ST_UNLOCKED;
                    edge_cnt_next = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_receiver.sv
// Randomized bench for tick_receiver against a timestamp-based reference model.
module tb_tick_receiver;

    localparam int          S  = 2;
    localparam logic [23:0] T  = 24'd20;
    localparam int          L  = 4;

    logic        clk_input = 1'b0;
    logic        rst_n = 1'b0;
    logic        slow_clk_in = 1'b0;
    logic        tick_rise, tick_fall, locked, timeout;
    logic [23:0] half_period;

    tick_receiver #(.SYNC_STAGES(S), .TIMEOUT_CYCLES(T), .LOCK_EDGES(L)) dut (
        .clk_input   (clk_input),
        .rst_n       (rst_n),
        .slow_clk_in (slow_clk_in),
        .tick_rise   (tick_rise),
        .tick_fall   (tick_fall),
        .half_period (half_period),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk_input = ~clk_input;

    int checks = 0;
    int errors = 0;

    // Reference model: samples seen by each clock edge, time of the last
    // edge/timeout/reset event, and edges accumulated since the last loss.
    bit          samples[$];
    int          cyc = 0;
    int          last_evt = 0;
    int          edges = 0;
    bit          in_lock = 0;
    bit          exp_rise, exp_fall, exp_to, exp_locked;
    logic [23:0] exp_hp = '0;
    bit          lvl = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        samples.delete();
        for (int i = 0; i < S + 2; i++) samples.push_back(1'b0);
        last_evt   = cyc;
        edges      = 0;
        in_lock    = 0;
        exp_rise   = 0;
        exp_fall   = 0;
        exp_to     = 0;
        exp_locked = 0;
        exp_hp     = '0;
    endtask

    task automatic model_step(input bit s, input bit r);
        bit lvl_at_edge, changed;
        int gap;
        cyc++;
        if (!r) begin
            model_reset();
            return;
        end
        samples.push_back(s);
        if (samples.size() > S + 2) void'(samples.pop_front());
        // The level now leaving the history flop versus the one before it.
        lvl_at_edge = samples[samples.size() - 1 - S];
        changed     = lvl_at_edge != samples[samples.size() - 2 - S];
        gap         = cyc - last_evt;
        exp_locked  = in_lock;
        exp_rise    = changed &&  lvl_at_edge;
        exp_fall    = changed && !lvl_at_edge;
        exp_to      = 0;
        if (changed) begin
            exp_hp   = (gap > 24'hFFFFFF) ? 24'hFFFFFF : 24'(gap);
            last_evt = cyc;
            edges    = edges + 1;
            in_lock  = edges >= L;
        end else if (gap == int'(T)) begin
            exp_to   = 1;
            last_evt = cyc;
            edges    = 0;
            in_lock  = 0;
        end
    endtask

    task automatic step(input bit s, input bit r);
        @(negedge clk_input);
        slow_clk_in = s;
        rst_n       = r;
        @(posedge clk_input);
        model_step(s, r);
        #1;
        check("tick_rise",   {31'b0, tick_rise}, {31'b0, exp_rise});
        check("tick_fall",   {31'b0, tick_fall}, {31'b0, exp_fall});
        check("timeout",     {31'b0, timeout},   {31'b0, exp_to});
        check("locked",      {31'b0, locked},    {31'b0, exp_locked});
        check("half_period", {8'b0, half_period}, {8'b0, exp_hp});
    endtask

    task automatic hold(input bit s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b1);
    endtask

    task automatic toggle_every(input int period, input int count);
        for (int i = 0; i < count; i++) begin
            lvl = !lvl;
            hold(lvl, period);
        end
    endtask

    initial begin
        model_reset();

        // Reset held low while the input toggles: everything stays at zero.
        for (int i = 0; i < 6; i++) step(i[0], 1'b0);
        lvl = 0;
        hold(lvl, 6);

        // Regular toggling acquires lock, then silence produces repeated timeouts.
        toggle_every(8, 7);
        hold(lvl, 70);

        // Period of exactly TIMEOUT_CYCLES: every edge lands on the timeout cycle.
        toggle_every(int'(T), 6);
        hold(lvl, 45);

        // Reset in the middle of locking, then lock again from scratch.
        toggle_every(6, 2);
        hold(lvl, 2);
        step(lvl, 1'b0);
        toggle_every(6, 6);

        // Input already high when reset releases counts as a rising edge.
        lvl = 1;
        step(lvl, 1'b0);
        step(lvl, 1'b0);
        hold(lvl, 10);

        // Random periods, long gaps, narrow pulses and occasional resets.
        for (int it = 0; it < 300; it++) begin
            int sel;
            sel = int'($urandom_range(0, 39));
            if (sel == 0) begin
                lvl = bit'($urandom_range(0, 1));
                for (int j = 0; j < int'($urandom_range(1, 3)); j++) step(lvl, 1'b0);
            end else if (sel < 4) begin
                lvl = !lvl;
                hold(lvl, int'($urandom_range(35, 65)));
            end else begin
                lvl = !lvl;
                hold(lvl, int'($urandom_range(1, 24)));
            end
        end
        hold(lvl, 25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_receiver.md
TICK_RECEIVER -- requirements
Module: tick_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2; synchronizer depth, minimum 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd3000000; maximum silence between synchronized edges.
REQ-003 SHALL have parameter LOCK_EDGES, default 4; number of consecutive in-time edges required for lock, range 1..15.
REQ-004 SHALL have port clk_input  in  1  system clock; the only clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port slow_clk_in  in  1  divided/toggling tick clock, asynchronous to clk_input.
REQ-007 SHALL have port tick_rise  out  1  one-cycle strobe on each synchronized rising edge.
REQ-008 SHALL have port tick_fall  out  1  one-cycle strobe on each synchronized falling edge.
REQ-009 SHALL have port half_period  out  24  clk_input cycles between the last two synchronized edges.
REQ-010 SHALL have port locked  out  1  high while the state machine is in LOCKED.
REQ-011 SHALL have port timeout  out  1  one-cycle strobe when TIMEOUT_CYCLES elapse with no edge.

Function
REQ-012 SHALL pass slow_clk_in through SYNC_STAGES flops and then one history flop; edge = sync output XOR history.
REQ-013 SHALL register all outputs; latency from the first clk_input edge sampling a new slow_clk_in level to the tick_rise/tick_fall strobe SHALL be SYNC_STAGES+1 cycles.
REQ-014 SHALL hold tick_rise and tick_fall high for exactly one cycle per edge; both SHALL never be high in the same cycle.
REQ-015 SHALL keep a 24-bit interval counter: cleared to 0 in an edge cycle, incremented otherwise, saturating at 24'hFFFFFF.
REQ-016 SHALL load half_period with interval counter + 1 (saturating) in each edge cycle; half_period holds its value otherwise.
REQ-017 SHALL pulse timeout when the interval counter reaches TIMEOUT_CYCLES-1 with no edge in that cycle, then clear the counter so timeout repeats every TIMEOUT_CYCLES cycles of silence.
REQ-018 SHALL give an edge priority over a simultaneous timeout: no timeout strobe in an edge cycle.
REQ-019 SHALL implement states UNLOCKED, LOCKING and LOCKED with a 4-bit edge count.
REQ-020 UNLOCKED: an edge -> LOCKING, edge count = 1; if LOCK_EDGES = 1 -> LOCKED directly.
REQ-021 LOCKING: an edge increments the edge count; when the count reaches LOCK_EDGES -> LOCKED.
REQ-022 Any state: a timeout -> UNLOCKED, edge count cleared; locked falls in the cycle after the timeout strobe.
REQ-023 LOCKED: edges keep the state; the edge count SHALL saturate at LOCK_EDGES.
REQ-024 locked SHALL be decoded from the registered state with no combinational path from slow_clk_in.

Reset
REQ-025 SHALL, while rst_n is low, force tick_rise=0, tick_fall=0, timeout=0, locked=0, half_period=0, interval counter=0, edge count=0, state=UNLOCKED, and all synchronizer and history flops=0.
REQ-026 SHALL treat slow_clk_in already high at reset release as one rising edge SYNC_STAGES+1 cycles after release.
REQ-027 SHALL, on reset mid-operation, discard all in-flight edges; no strobe SHALL appear while rst_n is low.

Structure
REQ-028 SHALL place the state encoding (2-bit UNLOCKED=0, LOCKING=1, LOCKED=2) and the default parameter constants in shared package tick_pkg.
REQ-029 SHALL implement the synchronizer as sub-module sync_ff (parameter STAGES, ports clk_input, rst_n, d, q), reusable elsewhere.
REQ-030 SHALL keep the edge detector, the interval counter and the FSM in tick_receiver.

Verification (SYNC_STAGES=2, TIMEOUT_CYCLES=20, LOCK_EDGES=4 unless stated)
REQ-031 Reset: hold rst_n low, toggle slow_clk_in -> all outputs stay 0; release with input low -> no strobe.
REQ-032 Latency and width: rise on slow_clk_in first sampled at cycle k -> tick_rise high only in cycle k+3; fall -> tick_fall likewise.
REQ-033 Lock and period: toggle every 8 cycles -> half_period=8 after the second edge; locked rises the cycle after the 4th edge.
REQ-034 Timeout: once locked, stop toggling -> timeout pulses 20 cycles after the last edge and every 20 cycles after that; locked drops on the cycle after the first pulse.
REQ-035 Priority: place an edge exactly in the cycle where the counter hits 19 -> tick strobe, no timeout, counter=0, half_period=20.
REQ-036 Reset mid-LOCKING: after 2 edges assert rst_n for 1 cycle -> state UNLOCKED; 3 further edges leave locked=0; the 4th sets locked.
